// File: rtl/nr4sd_pkg.sv
// Shared definitions for the sequential radix-4 multiplier.
//   MODE_*  : recoding scheme select values (3 is reserved and treated as MB)
//   digit_t : signed radix-4 digit, range -2..2
//   state_t : sequencer state encoding
package nr4sd_pkg;

    localparam logic [1:0] MODE_MB     = 2'd0;
    localparam logic [1:0] MODE_NR4SDM = 2'd1;
    localparam logic [1:0] MODE_NR4SDP = 2'd2;

    typedef logic signed [2:0] digit_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nr4sd_digit_recoder.sv
// Combinational recoder for one radix-4 digit of the multiplicand.
//   a_hi, a_lo : operand bits a[2k+1], a[2k]
//   a_prev     : a[2k-1] (0 for k=0), used as the incoming carry in MB mode
//   carry_in   : carry c_k from the previous digit (NR4SD modes)
//   mode       : recoding scheme
//   msd        : high when recoding the most significant digit
//   neg/one/two: digit in sign + one-hot magnitude form
//   carry_out  : carry c_{k+1} for the next digit
module nr4sd_digit_recoder
    import nr4sd_pkg::*;
(
    input  logic       a_hi,
    input  logic       a_lo,
    input  logic       a_prev,
    input  logic       carry_in,
    input  logic [1:0] mode,
    input  logic       msd,
    output logic       neg,
    output logic       one,
    output logic       two,
    output logic       carry_out
);

    logic              is_nr;
    logic              c;
    logic        [2:0] v;
    logic signed [3:0] y_w;
    digit_t            y;

    always_comb begin
        is_nr     = (mode == MODE_NR4SDM) || (mode == MODE_NR4SDP);
        c         = is_nr ? carry_in : a_prev;
        v         = {1'b0, a_hi, 1'b0} + {2'b00, a_lo} + {2'b00, c};
        y_w       = $signed({1'b0, v});
        carry_out = 1'b0;
        if (msd || !is_nr) begin
            // Booth digit: v - 4*a_hi == -2*a_hi + a_lo + c, no carry out
            if (a_hi) y_w = $signed({1'b0, v}) - 4'sd4;
        end else if ((mode == MODE_NR4SDP) ? (v >= 3'd3) : (v >= 3'd2)) begin
            y_w       = $signed({1'b0, v}) - 4'sd4;
            carry_out = 1'b1;
        end
        y   = y_w[2:0];
        neg = y[2];
        one = (y == 3'sd1) || (y == -3'sd1);
        two = (y == 3'sd2) || (y == -3'sd2);
    end

endmodule

// File: rtl/nr4sd_seq_multiplier.sv
// Iterative signed radix-4 multiplier, one recoded digit of a retired per clock.
//   clk, rst : clock and synchronous active-high reset
//   start    : request, accepted only while busy=0
//   mode     : 0=MB, 1=NR4SD-, 2=NR4SD+, 3=MB
//   a, b     : two's complement multiplicand (recoded) and multiplier
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse after the product is updated
//   product  : signed a*b, held until the next result
//
// state | meaning
// IDLE  | waiting for start; done may pulse in the first cycle here
// RUN   | retiring digit k_q each edge; leaves after digit D-1
module nr4sd_seq_multiplier
    import nr4sd_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product
);

    localparam int D  = N / 2;
    localparam int KW = (D > 1) ? $clog2(D) : 1;

    state_t           state_q,   state_d;
    logic [KW-1:0]    k_q,       k_d;
    logic [N-1:0]     a_q,       a_d;
    logic [N-1:0]     b_q,       b_d;
    logic [1:0]       mode_q,    mode_d;
    logic             carry_q,   carry_d;
    logic [2*N-1:0]   acc_q,     acc_d;
    logic [2*N-1:0]   product_q, product_d;
    logic             done_q,    done_d;

    logic             last;
    logic             a_prev;
    logic             neg, one, two, carry_out;
    logic [KW:0]      bit_idx;
    logic [N+1:0]     b_ext, pp_mag, pp;
    logic [2*N-1:0]   term;

    assign last    = (k_q == KW'(D - 1));
    assign bit_idx = {k_q, 1'b0};
    assign a_prev  = (k_q == '0) ? 1'b0 : a_q[{k_q - 1'b1, 1'b1}];

    nr4sd_digit_recoder u_recoder (
        .a_hi      (a_q[{k_q, 1'b1}]),
        .a_lo      (a_q[{k_q, 1'b0}]),
        .a_prev    (a_prev),
        .carry_in  (carry_q),
        .mode      (mode_q),
        .msd       (last),
        .neg       (neg),
        .one       (one),
        .two       (two),
        .carry_out (carry_out)
    );

    // y_k*b needs N+2 bits: |2b| can reach 2^N when b is the most negative value
    always_comb begin
        b_ext  = {{2{b_q[N-1]}}, b_q};
        pp_mag = two ? (b_ext << 1) : (one ? b_ext : '0);
        pp     = neg ? (~pp_mag + 1'b1) : pp_mag;
        term   = {{(N-2){pp[N+1]}}, pp} << bit_idx;
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        acc_d     = acc_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    k_d     = '0;
                    carry_d = 1'b0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                acc_d   = acc_q + term;
                carry_d = carry_out;
                k_d     = k_q + 1'b1;
                if (last) begin
                    state_d   = IDLE;
                    k_d       = '0;
                    product_d = acc_q + term;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= MODE_MB;
            carry_q   <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            a_q       <= a_d;
            b_q       <= b_d;
            mode_q    <= mode_d;
            carry_q   <= carry_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign product = product_q;

endmodule
